// File: rtl/morse_pkg.sv
// Shared state encoding, ASCII constants and length limits for the Morse decoder.
// Build option: MORSE_DIGIT_EN raises the maximum length to 5 so that digits 0-9 decode.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2,
        EMIT  = 2'd3
    } state_t;

    localparam int BUF_W = 5;

    localparam logic [7:0] CHAR_UNKNOWN = 8'h3F;
    localparam logic [7:0] CHAR_A       = 8'h41;
    localparam logic [7:0] CHAR_0       = 8'h30;

    localparam logic [2:0] MAX_LEN_ALPHA = 3'd4;
    localparam logic [2:0] MAX_LEN_DIGIT = 3'd5;

`ifdef MORSE_DIGIT_EN
    localparam logic [2:0] MAX_LEN = MAX_LEN_DIGIT;
`else
    localparam logic [2:0] MAX_LEN = MAX_LEN_ALPHA;
`endif

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse table: {symbol count, pattern} -> ASCII code plus invalid flag.
// Build option: MORSE_DIGIT_EN adds the 5-symbol digit rows. Dot = 0, dash = 1, first symbol is the MSB.
module morse_lut
    import morse_pkg::*;
(
    input  logic [2:0]       count,
    input  logic [BUF_W-1:0] pattern,
    output logic [7:0]       code,
    output logic             invalid
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        code    = CHAR_UNKNOWN;
        invalid = 1'b0;
        case ({count, pattern})
            {3'd1, 5'b00000}: code = CHAR_A + 8'd4;   // E
            {3'd1, 5'b00001}: code = CHAR_A + 8'd19;  // T
            {3'd2, 5'b00001}: code = CHAR_A + 8'd0;   // A
            {3'd2, 5'b00000}: code = CHAR_A + 8'd8;   // I
            {3'd2, 5'b00011}: code = CHAR_A + 8'd12;  // M
            {3'd2, 5'b00010}: code = CHAR_A + 8'd13;  // N
            {3'd3, 5'b00100}: code = CHAR_A + 8'd3;   // D
            {3'd3, 5'b00110}: code = CHAR_A + 8'd6;   // G
            {3'd3, 5'b00101}: code = CHAR_A + 8'd10;  // K
            {3'd3, 5'b00111}: code = CHAR_A + 8'd14;  // O
            {3'd3, 5'b00010}: code = CHAR_A + 8'd17;  // R
            {3'd3, 5'b00000}: code = CHAR_A + 8'd18;  // S
            {3'd3, 5'b00001}: code = CHAR_A + 8'd20;  // U
            {3'd3, 5'b00011}: code = CHAR_A + 8'd22;  // W
            {3'd4, 5'b01000}: code = CHAR_A + 8'd1;   // B
            {3'd4, 5'b01010}: code = CHAR_A + 8'd2;   // C
            {3'd4, 5'b00010}: code = CHAR_A + 8'd5;   // F
            {3'd4, 5'b00000}: code = CHAR_A + 8'd7;   // H
            {3'd4, 5'b00111}: code = CHAR_A + 8'd9;   // J
            {3'd4, 5'b00100}: code = CHAR_A + 8'd11;  // L
            {3'd4, 5'b00110}: code = CHAR_A + 8'd15;  // P
            {3'd4, 5'b01101}: code = CHAR_A + 8'd16;  // Q
            {3'd4, 5'b00001}: code = CHAR_A + 8'd21;  // V
            {3'd4, 5'b01001}: code = CHAR_A + 8'd23;  // X
            {3'd4, 5'b01011}: code = CHAR_A + 8'd24;  // Y
            {3'd4, 5'b01100}: code = CHAR_A + 8'd25;  // Z
`ifdef MORSE_DIGIT_EN
            {3'd5, 5'b11111}: code = CHAR_0 + 8'd0;
            {3'd5, 5'b01111}: code = CHAR_0 + 8'd1;
            {3'd5, 5'b00111}: code = CHAR_0 + 8'd2;
            {3'd5, 5'b00011}: code = CHAR_0 + 8'd3;
            {3'd5, 5'b00001}: code = CHAR_0 + 8'd4;
            {3'd5, 5'b00000}: code = CHAR_0 + 8'd5;
            {3'd5, 5'b10000}: code = CHAR_0 + 8'd6;
            {3'd5, 5'b11000}: code = CHAR_0 + 8'd7;
            {3'd5, 5'b11100}: code = CHAR_0 + 8'd8;
            {3'd5, 5'b11110}: code = CHAR_0 + 8'd9;
`endif
            default: begin
                code    = CHAR_UNKNOWN;
                invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/morse_decoder.sv
// Morse key decoder: collects dot/dash symbols and emits one ASCII character after an idle gap.
// Build option: MORSE_DIGIT_EN (via morse_pkg/morse_lut) enables 5-symbol digits.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int unsigned          T_GAP_BIT = 26,
    parameter logic [T_GAP_BIT-1:0] T_GAP     = 26'h2FA_F080
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       bt_start,
    input  logic       bt_done,
    input  logic       length,
    output logic       char_valid,
    output logic [7:0] char_code,
    output logic       char_err,
    output logic [2:0] sym_count,
    output logic       busy
);

    localparam logic [T_GAP_BIT-1:0] GAP_ONE  = {{(T_GAP_BIT-1){1'b0}}, 1'b1};
    localparam logic [T_GAP_BIT-1:0] GAP_LAST = T_GAP - GAP_ONE;

    state_t                 state;
    state_t                 state_next;
    logic [BUF_W-1:0]       sym_buf;
    logic                   err;
    logic [T_GAP_BIT-1:0]   gap_cnt;
    logic [7:0]             lut_code;
    logic                   lut_invalid;

    morse_lut u_lut (
        .count   (sym_count),
        .pattern (sym_buf),
        .code    (lut_code),
        .invalid (lut_invalid)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (bt_start) state_next = PRESS;
            PRESS: if (bt_done)  state_next = GAP;
            GAP: begin
                if (bt_start)                 state_next = PRESS;
                else if (gap_cnt == GAP_LAST) state_next = EMIT;
            end
            EMIT:    state_next = bt_start ? PRESS : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sym_buf    <= '0;
            sym_count  <= '0;
            err        <= 1'b0;
            gap_cnt    <= '0;
            char_valid <= 1'b0;
            char_code  <= 8'h00;
            char_err   <= 1'b0;
        end else begin
            char_valid <= 1'b0;
            char_err   <= 1'b0;

            // Outputs are registered on the GAP->EMIT edge so they are valid during EMIT.
            if (state == GAP && state_next == EMIT) begin
                char_valid <= 1'b1;
                char_code  <= (err || lut_invalid) ? CHAR_UNKNOWN : lut_code;
                char_err   <= err || lut_invalid;
            end

            if (state == GAP && !bt_start) begin
                if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + GAP_ONE;
            end else begin
                gap_cnt <= '0;
            end

            if (state == EMIT) begin
                sym_buf   <= '0;
                sym_count <= '0;
                err       <= 1'b0;
            end else if (state == PRESS && bt_done) begin
                // A symbol beyond the maximum length only marks the character as bad.
                if (sym_count == MAX_LEN) begin
                    err <= 1'b1;
                end else begin
                    sym_buf   <= {sym_buf[BUF_W-2:0], length};
                    sym_count <= sym_count + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench for morse_decoder with T_GAP=4: stimulus queues expected characters, a monitor checks them.
// Expectations follow MORSE_DIGIT_EN the same way the design does.
module tb_morse_decoder;

    localparam int unsigned T_GAP_BIT = 4;
    localparam logic [3:0]  T_GAP     = 4'd4;

`ifdef MORSE_DIGIT_EN
    localparam logic [2:0] MAX_LEN       = 3'd5;
    localparam logic [7:0] FIVE_DASH     = 8'h30;
    localparam logic       FIVE_DASH_ERR = 1'b0;
`else
    localparam logic [2:0] MAX_LEN       = 3'd4;
    localparam logic [7:0] FIVE_DASH     = 8'h3F;
    localparam logic       FIVE_DASH_ERR = 1'b1;
`endif

    typedef struct {
        logic [7:0] code;
        logic       err;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       bt_start = 1'b0;
    logic       bt_done = 1'b0;
    logic       length = 1'b0;
    logic       char_valid;
    logic [7:0] char_code;
    logic       char_err;
    logic [2:0] sym_count;
    logic       busy;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cyc = 0;
    int   emitted = 0;
    int   expected_emits = 0;

    morse_decoder #(
        .T_GAP_BIT (T_GAP_BIT),
        .T_GAP     (T_GAP)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .bt_start   (bt_start),
        .bt_done    (bt_done),
        .length     (length),
        .char_valid (char_valid),
        .char_code  (char_code),
        .char_err   (char_err),
        .sym_count  (sym_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (n_rst && char_valid) begin
            emitted++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_char: got code=%0h err=%0b expected no char_valid (cycle %0d)",
                         char_code, char_err, cyc);
            end else begin
                e = exp_q.pop_front();
                check("char_code", char_code, e.code);
                check("char_err", char_err, e.err);
                check("emit_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic dash);
        bt_start = 1'b1;
        tick();
        bt_start = 1'b0;
        bt_done  = 1'b1;
        length   = dash;
        done_cyc = cyc;
        tick();
        bt_done  = 1'b0;
        length   = 1'b0;
    endtask

    task automatic expect_char(input logic [7:0] code, input logic err);
        exp_t e;
        e.code = code;
        e.err  = err;
        e.cyc  = done_cyc + int'(T_GAP) + 1;
        exp_q.push_back(e);
        expected_emits++;
    endtask

    task automatic settle();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 30) begin
            tick();
            n++;
        end
        check("settle_in_time", (n < 30), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(2);
        check("rst_busy", busy, 0);
        check("rst_sym_count", sym_count, 0);
        check("rst_char_code", char_code, 8'h00);
        check("rst_char_valid", char_valid, 0);
        check("rst_char_err", char_err, 0);
        n_rst = 1'b1;
        tick(2);

        // Stray bt_done/length in IDLE are ignored.
        bt_done = 1'b1;
        length  = 1'b1;
        tick();
        bt_done = 1'b0;
        length  = 1'b0;
        tick();
        check("stray_busy", busy, 0);
        check("stray_sym_count", sym_count, 0);

        // A: dot dash, emitted 5 cycles after the last bt_done.
        press(1'b0);
        press(1'b1);
        expect_char(8'h41, 1'b0);
        settle();

        // B: dash dot dot dot.
        press(1'b1);
        press(1'b0);
        press(1'b0);
        press(1'b0);
        check("b_sym_count_before", sym_count, 4);
        expect_char(8'h42, 1'b0);
        settle();
        check("b_sym_count_after", sym_count, 0);

        // Five dashes: '0' with digits, overflow otherwise.
        repeat (5) press(1'b1);
        expect_char(FIVE_DASH, FIVE_DASH_ERR);
        settle();

        // Six dots always overflow; count sticks at the maximum.
        repeat (6) press(1'b0);
        check("ovf_sym_count", sym_count, 32'(MAX_LEN));
        expect_char(8'h3F, 1'b1);
        settle();
        check("ovf_cleared", sym_count, 0);

        // E, with the next key press landing in the EMIT cycle, followed by T.
        press(1'b0);
        expect_char(8'h45, 1'b0);
        tick(4);
        press(1'b1);
        expect_char(8'h54, 1'b0);
        settle();

        // bt_start on the last gap cycle continues the character: ..-- is not in the table.
        press(1'b0);
        press(1'b0);
        tick(3);
        press(1'b1);
        press(1'b1);
        check("cont_sym_count", sym_count, 4);
        expect_char(8'h3F, 1'b1);
        settle();

        // Z: dash dash dot dot.
        press(1'b1);
        press(1'b1);
        press(1'b0);
        press(1'b0);
        expect_char(8'h5A, 1'b0);
        settle();

        // Reset during GAP discards the partial character.
        press(1'b0);
        press(1'b0);
        tick();
        n_rst = 1'b0;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_sym_count", sym_count, 0);
        check("midrst_char_code", char_code, 8'h00);
        n_rst = 1'b1;
        tick(10);
        check("post_rst_busy", busy, 0);
        check("post_rst_sym_count", sym_count, 0);

        tick(2);
        check("queue_empty", exp_q.size(), 0);
        check("emit_count", emitted, expected_emits);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
